regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard_sb_counter.sv | 55 +++++
 rtl/regfile_scoreboard.sv | 145 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_PEND_W = 2;

  // Largest value a pending-write counter of the given width can hold.
  function automatic int sat_limit(input int pend_w);
    return (32'sd1 <<< pend_w) - 32'sd1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One saturating pending-write counter: +1 on issue, -0..2 per cycle on
// write-back/cancel, clamped at both ends; underflow pulses when the net
// result would go below zero.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [1:0]        dec,
  output logic [PEND_W-1:0] count,
  output logic              underflow
);

  localparam logic [PEND_W+1:0] LIMIT = (PEND_W+2)'(sat_limit(PEND_W));

  logic [PEND_W-1:0] count_r;
  logic [PEND_W+1:0] sum_s;
  logic [PEND_W+1:0] dec_ext_s;
  logic [PEND_W+1:0] diff_s;
  logic [PEND_W-1:0] next_s;
  logic              uf_s;

  // Net update of increment and decrements with clamping at 0 and at the limit.
  always_comb begin
    sum_s     = {2'b00, count_r} + {{(PEND_W+1){1'b0}}, inc};
    dec_ext_s = {{PEND_W{1'b0}}, dec};
    diff_s    = sum_s - dec_ext_s;
    next_s    = count_r;
    uf_s      = 1'b0;
    if (sum_s < dec_ext_s) begin
      next_s = {PEND_W{1'b0}};
      uf_s   = 1'b1;
    end else if (diff_s > LIMIT) begin
      next_s = LIMIT[PEND_W-1:0];
    end else begin
      next_s = diff_s[PEND_W-1:0];
    end
  end

  // Counter state; reset discards outstanding counts immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {PEND_W{1'b0}};
    end else begin
      count_r <= next_s;
    end
  end

  assign count     = count_r;
  assign underflow = uf_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard for decode stall.
// Optional build macro REGFILE_BYPASS_EN: a same-cycle write-back is forwarded
// to matching read ports and counts as already retired for the stall check.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     cancel_en,
  input  logic [ADDR_W-1:0]        cancel_addr,
  output logic                     hazard,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic                     underflow
);

  localparam int                NUM_REG = 2**ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(sat_limit(PEND_W));

  logic [DATA_W-1:0]  regs_r    [NUM_REG];
  logic [PEND_W-1:0]  cnt_s     [NUM_REG];
  logic [PEND_W-1:0]  eff_cnt_s [NUM_REG];
  logic [1:0]         dec_s     [NUM_REG];
  logic [NUM_REG-1:0] wb_hit_s;
  logic [NUM_REG-1:0] cancel_hit_s;
  logic [NUM_REG-1:0] inc_s;
  logic [NUM_REG-1:0] uf_s;
  logic               hazard_s;
  logic               issue_ok_s;
  logic               underflow_r;

  // Per-register decrement requests from write-back and cancel.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      wb_hit_s[r]     = wb_en & (wb_addr == ADDR_W'(r));
      cancel_hit_s[r] = cancel_en & (cancel_addr == ADDR_W'(r));
      dec_s[r]        = {1'b0, wb_hit_s[r]} + {1'b0, cancel_hit_s[r]};
    end
  end

  // Outstanding writes as seen by the stall check (bypass retires the current write-back).
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_hit_s[r] && (cnt_s[r] != {PEND_W{1'b0}})) begin
        eff_cnt_s[r] = cnt_s[r] - {{(PEND_W-1){1'b0}}, 1'b1};
      end else begin
        eff_cnt_s[r] = cnt_s[r];
      end
`else
      eff_cnt_s[r] = cnt_s[r];
`endif
    end
  end

  // Stall on a used source with an outstanding write, or on a saturated destination.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      hazard_s = hazard_s | (rd_used[i] &
                 (eff_cnt_s[rd_addr[i*ADDR_W +: ADDR_W]] != {PEND_W{1'b0}}));
    end
    hazard_s = hazard_s | (issue_en & (eff_cnt_s[issue_dest] == CNT_MAX));
  end

  // Accepted issue increments only the destination counter.
  always_comb begin
    issue_ok_s = issue_en & ~hazard_s;
    for (int r = 0; r < NUM_REG; r++) begin
      inc_s[r] = issue_ok_s & (issue_dest == ADDR_W'(r));
    end
  end

  for (genvar r = 0; r < NUM_REG; r++) begin : g_cnt
    sb_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_s[r]),
      .dec       (dec_s[r]),
      .count     (cnt_s[r]),
      .underflow (uf_s[r])
    );
  end

  // Read ports: stored value, optionally overridden by a same-cycle write-back.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_data[i*DATA_W +: DATA_W] =
        (wb_en && (rd_addr[i*ADDR_W +: ADDR_W] == wb_addr)) ?
        wb_data : regs_r[rd_addr[i*ADDR_W +: ADDR_W]];
`else
      rd_data[i*DATA_W +: DATA_W] = regs_r[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
    end
  end

  // Pending flag per register.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      pending[r] = (cnt_s[r] != {PEND_W{1'b0}});
    end
  end

  // Register storage; write-back data lands even when its counter underflows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REG; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
    end else if (wb_en) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[wb_addr] <= regs_r[wb_addr];
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_r <= 1'b0;
    end else begin
      underflow_r <= underflow_r | (|uf_s);
    end
  end

  assign hazard    = hazard_s;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a counter/array reference model.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 3;  // 2**PEND_W - 1 with PEND_W = 2

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  logic [1:0]  rd_used = 2'b00;
  logic [63:0] rd_data;
  logic        issue_en = 1'b0;
  logic [3:0]  issue_dest = 4'd0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = 4'd0;
  logic [31:0] wb_data = 32'h0;
  logic        cancel_en = 1'b0;
  logic [3:0]  cancel_addr = 4'd0;
  logic        hazard;
  logic [15:0] pending;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;

  int        cnt_m [16];
  bit [31:0] reg_m [16];
  bit        uf_m;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .issue_en(issue_en), .issue_dest(issue_dest), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .cancel_en(cancel_en), .cancel_addr(cancel_addr),
    .hazard(hazard), .pending(pending), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Writes still outstanding at register a as the stall rule sees them.
  function automatic int m_out(input int a);
    int o;
    o = cnt_m[a];
    if (BYP && wb_en && (int'(wb_addr) == a) && o > 0) o = o - 1;
    return o;
  endfunction

  function automatic bit m_hazard();
    bit h;
    h = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rd_used[i] && m_out(int'(rd_addr[i*4 +: 4])) > 0) h = 1'b1;
    end
    if (issue_en && m_out(int'(issue_dest)) == MAXC) h = 1'b1;
    return h;
  endfunction

  function automatic bit [31:0] m_rd(input int i);
    int a;
    a = int'(rd_addr[i*4 +: 4]);
    if (BYP && wb_en && int'(wb_addr) == a) return wb_data;
    return reg_m[a];
  endfunction

  function automatic bit [15:0] m_pending();
    bit [15:0] p;
    for (int r = 0; r < 16; r++) p[r] = (cnt_m[r] != 0);
    return p;
  endfunction

  function automatic int m_raw_next(input int r);
    int n;
    n = cnt_m[r];
    if (issue_en && !m_hazard() && int'(issue_dest) == r) n = n + 1;
    if (wb_en && int'(wb_addr) == r) n = n - 1;
    if (cancel_en && int'(cancel_addr) == r) n = n - 1;
    return n;
  endfunction

  function automatic int m_next(input int r);
    int n;
    n = m_raw_next(r);
    if (n < 0) n = 0;
    if (n > MAXC) n = MAXC;
    return n;
  endfunction

  function automatic bit m_any_uf();
    bit u;
    u = 1'b0;
    for (int r = 0; r < 16; r++) if (m_raw_next(r) < 0) u = 1'b1;
    return u;
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin
        cnt_m[r] <= 0;
        reg_m[r] <= 32'h0;
      end
      uf_m <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_m[r] <= m_next(r);
      uf_m <= uf_m | m_any_uf();
      if (wb_en) reg_m[wb_addr] <= wb_data;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("hazard", {63'd0, hazard}, {63'd0, m_hazard()});
    chk("rd_data0", {32'd0, rd_data[31:0]}, {32'd0, m_rd(0)});
    chk("rd_data1", {32'd0, rd_data[63:32]}, {32'd0, m_rd(1)});
    chk("pending", {48'd0, pending}, {48'd0, m_pending()});
    chk("underflow", {63'd0, underflow}, {63'd0, uf_m});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    issue_en  = 1'b0;
    wb_en     = 1'b0;
    cancel_en = 1'b0;
    rd_used   = 2'b00;
  endtask

  task automatic do_issue(input logic [3:0] d);
    issue_en = 1'b1; issue_dest = d; tick();
  endtask

  task automatic do_wb(input logic [3:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d; tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", {48'd0, pending}, 64'h0);
    chk("rst_hazard", {63'd0, hazard}, 64'h0);
    chk("rst_underflow", {63'd0, underflow}, 64'h0);
    chk("rst_rd_data", rd_data, 64'h0);
    rst = 1'b1;

    // Asynchronous reset after three outstanding issues
    do_issue(4'd1);
    do_wb(4'd1, 32'h1111_1111);
    do_issue(4'd1);
    do_issue(4'd2);
    do_issue(4'd3);
    rd_addr = 8'h01; rd_used = 2'b01;
    #1;
    chk("pre_rst_rd", {32'd0, rd_data[31:0]}, 64'h1111_1111);
    chk("pre_rst_pending", {48'd0, pending}, 64'h000E);
    chk("pre_rst_hazard", {63'd0, hazard}, 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_pending", {48'd0, pending}, 64'h0);
    chk("async_rst_hazard", {63'd0, hazard}, 64'h0);
    chk("async_rst_rd", {32'd0, rd_data[31:0]}, 64'h0);
    #3 rst = 1'b1;
    tick();

    // Read-after-write stall and release
    do_issue(4'd3);
    rd_addr = 8'h03; rd_used = 2'b01;
    #1 chk("raw_hazard", {63'd0, hazard}, 64'h1);
    tick();
    rd_used = 2'b01; wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF;
    #1 chk("raw_wb_cycle_hazard", {63'd0, hazard}, BYP ? 64'h0 : 64'h1);
    tick();
    rd_used = 2'b01;
    #1;
    chk("raw_clear_hazard", {63'd0, hazard}, 64'h0);
    chk("raw_rd_data", {32'd0, rd_data[31:0]}, 64'hDEAD_BEEF);
    tick();

    // Unused source does not stall
    do_issue(4'd5);
    rd_addr = {4'd5, 4'd3}; rd_used = 2'b00;
    #1 chk("unused_hazard", {63'd0, hazard}, 64'h0);
    rd_used = 2'b10;
    #1 chk("used_port1_hazard", {63'd0, hazard}, 64'h1);
    rd_used = 2'b00;
    do_wb(4'd5, 32'h0000_0005);

    // Saturation at three outstanding writes
    do_issue(4'd7);
    do_issue(4'd7);
    do_issue(4'd7);
    issue_en = 1'b1; issue_dest = 4'd7;
    #1 chk("sat_hazard", {63'd0, hazard}, 64'h1);
    tick();
    chk("sat_model_cnt", 64'(cnt_m[7]), 64'd3);
    issue_en = 1'b1; issue_dest = 4'd7;
    #1 chk("sat_still_hazard", {63'd0, hazard}, 64'h1);
    issue_en = 1'b0;
    do_wb(4'd7, 32'h0000_0077);
    chk("sat_model_after_wb", 64'(cnt_m[7]), 64'd2);
    issue_en = 1'b1; issue_dest = 4'd7;
    #1 chk("sat_after_wb_hazard", {63'd0, hazard}, 64'h0);
    issue_en = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h0000_0078;
    cancel_en = 1'b1; cancel_addr = 4'd7;
    tick();
    chk("sat_drained", {63'd0, pending[7]}, 64'h0);

    // Simultaneous events on one register
    do_issue(4'd2);
    issue_en = 1'b1; issue_dest = 4'd2;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h0000_0022;
    tick();
    chk("issue_wb_model_cnt", 64'(cnt_m[2]), 64'd1);
    chk("issue_wb_pending", {63'd0, pending[2]}, 64'h1);
    do_issue(4'd2);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h0000_0023;
    cancel_en = 1'b1; cancel_addr = 4'd2;
    tick();
    chk("wb_cancel_pending", {63'd0, pending[2]}, 64'h0);
    chk("wb_cancel_no_uf", {63'd0, underflow}, 64'h0);
    cancel_en = 1'b1; cancel_addr = 4'd9;
    tick();
    chk("cancel_uf", {63'd0, underflow}, 64'h1);
    tick();
    chk("cancel_uf_held", {63'd0, underflow}, 64'h1);
    do_wb(4'd10, 32'h0000_A5A5);
    rd_addr = 8'h0A;
    #1 chk("uf_wb_data_written", {32'd0, rd_data[31:0]}, 64'hA5A5);

    // Same-cycle write-back visibility
    do_issue(4'd4);
    rd_addr = 8'h04; rd_used = 2'b01;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h0000_0055;
    #1;
    chk("bypass_rd", {32'd0, rd_data[31:0]}, BYP ? 64'h55 : 64'h0);
    chk("bypass_hazard", {63'd0, hazard}, BYP ? 64'h0 : 64'h1);
    tick();
    rd_used = 2'b01;
    #1;
    chk("post_wb_rd", {32'd0, rd_data[31:0]}, 64'h55);
    chk("post_wb_hazard", {63'd0, hazard}, 64'h0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
